// File: rtl/muldiv_pkg.sv
// Shared encodings for the Execute-stage multiply/divide unit: op codes,
// FSM states and the default datapath width.
package muldiv_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        SIGN = 2'b10
    } state_e;

    // Op[0] clear means the operands are two's complement.
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply (product shifts right) or
// restoring subtract/shift for divide ({remainder, quotient} shifts left).
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                    mode_div,
    input  logic [2*DATA_WIDTH-1:0] acc,
    input  logic [DATA_WIDTH-1:0]   operand,
    output logic [2*DATA_WIDTH-1:0] acc_next,
    output logic                    q_bit
);

    logic [DATA_WIDTH:0] add_sum;
    logic [DATA_WIDTH:0] rem_shift;
    logic [DATA_WIDTH:0] diff;

    always_comb begin
        add_sum   = {1'b0, acc[2*DATA_WIDTH-1:DATA_WIDTH]}
                  + (acc[0] ? {1'b0, operand} : {(DATA_WIDTH+1){1'b0}});
        rem_shift = {acc[2*DATA_WIDTH-1:DATA_WIDTH], acc[DATA_WIDTH-1]};
        diff      = rem_shift - {1'b0, operand};
        q_bit     = 1'b0;
        acc_next  = '0;
        if (mode_div) begin
            // rem_shift <= 2*divisor-1, so the top bit of diff is a clean borrow flag.
            q_bit    = ~diff[DATA_WIDTH];
            acc_next = {(q_bit ? diff[DATA_WIDTH-1:0] : rem_shift[DATA_WIDTH-1:0]),
                        acc[DATA_WIDTH-2:0], 1'b0};
        end else begin
            acc_next = {add_sum, acc[DATA_WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/execute_muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO
// registers; Busy lets hazard logic stall MFHI/MFLO and further issue.
module execute_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    input  logic                  Start,
    input  logic [1:0]            Op,
    input  logic [DATA_WIDTH-1:0] OperandA,
    input  logic [DATA_WIDTH-1:0] OperandB,
    input  logic                  Flush,
    input  logic                  WriteHI,
    input  logic                  WriteLO,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic [DATA_WIDTH-1:0] HI,
    output logic [DATA_WIDTH-1:0] LO,
    output logic                  Busy,
    output logic                  Done,
    output logic                  DivByZero,
    output state_e                dbg_state
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DATA_WIDTH - 1);

    state_e                  state, state_next;
    logic [CNT_W-1:0]        count;
    logic [2*DATA_WIDTH-1:0] acc, step_acc, prod_signed;
    logic [DATA_WIDTH-1:0]   operand, hi_q, lo_q, quot_signed, rem_signed;
    logic [DATA_WIDTH-1:0]   mag_a, mag_b;
    logic                    op_div, res_neg, rem_neg;
    logic                    dbz_pending, done_q, dbz_q, step_q;
    logic                    a_neg, b_neg, start_ok, start_dbz, write_ok;

    // Handshake: Start is taken only while Busy is low and Flush is low; every
    // accepted op ends in exactly one Done pulse unless Flush or reset aborts it.
    always_comb begin
        a_neg       = op_is_signed(Op) & OperandA[DATA_WIDTH-1];
        b_neg       = op_is_signed(Op) & OperandB[DATA_WIDTH-1];
        mag_a       = a_neg ? -OperandA : OperandA;
        mag_b       = b_neg ? -OperandB : OperandB;
        start_ok    = (state == IDLE) && Start && !Flush;
        start_dbz   = start_ok && op_is_div(Op) && (OperandB == '0);
        write_ok    = (state == IDLE) && !Start && !Flush;
        prod_signed = res_neg ? -acc : acc;
        quot_signed = res_neg ? -acc[DATA_WIDTH-1:0] : acc[DATA_WIDTH-1:0];
        rem_signed  = rem_neg ? -acc[2*DATA_WIDTH-1:DATA_WIDTH]
                              : acc[2*DATA_WIDTH-1:DATA_WIDTH];
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start_ok && !start_dbz) state_next = CALC;
            CALC: begin
                if (Flush)                    state_next = IDLE;
                else if (count == LAST_COUNT) state_next = SIGN;
            end
            SIGN:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_next;
    end

    muldiv_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .mode_div (op_div),
        .acc      (acc),
        .operand  (operand),
        .acc_next (step_acc),
        .q_bit    (step_q)
    );

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            acc         <= '0;
            operand     <= '0;
            count       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            op_div      <= 1'b0;
            res_neg     <= 1'b0;
            rem_neg     <= 1'b0;
            dbz_pending <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            dbz_pending <= 1'b0;
            // A zero divisor is reported one edge after acceptance, with no busy phase.
            if (dbz_pending && !Flush) begin
                done_q <= 1'b1;
                dbz_q  <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        op_div      <= op_is_div(Op);
                        res_neg     <= a_neg ^ b_neg;
                        rem_neg     <= a_neg;
                        count       <= '0;
                        operand     <= op_is_div(Op) ? mag_b : mag_a;
                        acc         <= {{DATA_WIDTH{1'b0}}, (op_is_div(Op) ? mag_a : mag_b)};
                        dbz_pending <= start_dbz;
                    end else if (write_ok) begin
                        if (WriteHI) hi_q <= WriteData;
                        if (WriteLO) lo_q <= WriteData;
                    end
                end
                CALC: begin
                    if (!Flush) begin
                        acc   <= step_acc | {{(2*DATA_WIDTH-1){1'b0}}, step_q};
                        count <= count + 1'b1;
                    end
                end
                SIGN: begin
                    if (!Flush) begin
                        if (op_div) begin
                            hi_q <= rem_signed;
                            lo_q <= quot_signed;
                        end else begin
                            {hi_q, lo_q} <= prod_signed;
                        end
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign HI        = hi_q;
    assign LO        = lo_q;
    assign Busy      = (state != IDLE);
    assign Done      = done_q;
    assign DivByZero = dbz_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Directed bench for execute_muldiv_unit: multiply/divide results, timing of
// Busy/Done, divide-by-zero, MTHI/MTLO, Flush and asynchronous reset.
module tb_execute_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         Clock = 1'b0;
    logic         Reset_n = 1'b0;
    logic         Start = 1'b0;
    logic [1:0]   Op = 2'b00;
    logic [W-1:0] OperandA = '0;
    logic [W-1:0] OperandB = '0;
    logic         Flush = 1'b0;
    logic         WriteHI = 1'b0;
    logic         WriteLO = 1'b0;
    logic [W-1:0] WriteData = '0;
    logic [W-1:0] HI, LO;
    logic         Busy, Done, DivByZero;
    state_e       dbg_state;

    int checks = 0;
    int errors = 0;
    int busy_cycles, done_pulses, dbz_pulses, done_at, dbz_at;

    execute_muldiv_unit #(.DATA_WIDTH(W)) dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .Start     (Start),
        .Op        (Op),
        .OperandA  (OperandA),
        .OperandB  (OperandB),
        .Flush     (Flush),
        .WriteHI   (WriteHI),
        .WriteLO   (WriteLO),
        .WriteData (WriteData),
        .HI        (HI),
        .LO        (LO),
        .Busy      (Busy),
        .Done      (Done),
        .DivByZero (DivByZero),
        .dbg_state (dbg_state)
    );

    always #5 Clock = ~Clock;

    // Presents Start for exactly one edge (E0); returns #1 after E0.
    task automatic drive_start(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge Clock);
        Start = 1'b1; Op = op; OperandA = a; OperandB = b;
        @(posedge Clock); #1;
        Start = 1'b0;
    endtask

    // Launches an op and watches 40 cycles after E0 (sample i is #1 after edge E<i>).
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        drive_start(op, a, b);
        busy_cycles = 0; done_pulses = 0; dbz_pulses = 0; done_at = -1; dbz_at = -1;
        for (int i = 0; i < 40; i++) begin
            if (Busy) busy_cycles++;
            if (Done) begin done_pulses++; done_at = i; end
            if (DivByZero) begin dbz_pulses++; dbz_at = i; end
            @(posedge Clock); #1;
        end
    endtask

    task automatic write_regs(input logic hi, input logic lo, input logic [W-1:0] data);
        @(negedge Clock);
        WriteHI = hi; WriteLO = lo; WriteData = data;
        @(posedge Clock); #1;
        WriteHI = 1'b0; WriteLO = 1'b0;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        #12;
        checks++; if (HI !== '0) begin errors++; $display("FAIL reset_hi: got %h expected %h", HI, 32'h0); end
        checks++; if (LO !== '0) begin errors++; $display("FAIL reset_lo: got %h expected %h", LO, 32'h0); end
        checks++; if ({Busy, Done, DivByZero} !== 3'b000) begin errors++; $display("FAIL reset_flags: got busy/done/dbz %b expected 000", {Busy, Done, DivByZero}); end
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE); end
        @(negedge Clock);
        Reset_n = 1'b1;
    endtask

    task automatic test_multu_max();
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checks++; if (busy_cycles != 33) begin errors++; $display("FAIL multu_busy_cycles: got %0d expected 33", busy_cycles); end
        checks++; if (done_at != 33) begin errors++; $display("FAIL multu_done_cycle: got %0d expected 33", done_at); end
        checks++; if (done_pulses != 1) begin errors++; $display("FAIL multu_done_pulses: got %0d expected 1", done_pulses); end
        checks++; if (dbz_pulses != 0) begin errors++; $display("FAIL multu_dbz: got %0d expected 0", dbz_pulses); end
        checks++; if (HI !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h expected %h", HI, 32'hFFFF_FFFE); end
        checks++; if (LO !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h expected %h", LO, 32'h0000_0001); end
    endtask

    task automatic test_mult_then_divu();
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_neg_hi: got %h expected %h", HI, 32'hFFFF_FFFF); end
        checks++; if (LO !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_neg_lo: got %h expected %h", LO, 32'hFFFF_FFEB); end
        run_op(OP_DIVU, 32'd100, 32'd7);
        checks++; if (LO !== 32'd14) begin errors++; $display("FAIL divu_lo: got %h expected %h", LO, 32'd14); end
        checks++; if (HI !== 32'd2) begin errors++; $display("FAIL divu_hi: got %h expected %h", HI, 32'd2); end
        checks++; if (done_at != 33 || busy_cycles != 33) begin errors++; $display("FAIL divu_timing: got done_at %0d busy %0d expected 33 33", done_at, busy_cycles); end
    endtask

    task automatic test_div_signed();
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        checks++; if (LO !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_lo: got %h expected %h", LO, 32'hFFFF_FFFD); end
        checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_hi: got %h expected %h", HI, 32'hFFFF_FFFF); end
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        checks++; if (LO !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo: got %h expected %h", LO, 32'h8000_0000); end
        checks++; if (HI !== 32'h0) begin errors++; $display("FAIL div_ovf_hi: got %h expected %h", HI, 32'h0); end
        checks++; if (dbz_pulses != 0) begin errors++; $display("FAIL div_ovf_dbz: got %0d expected 0", dbz_pulses); end
    endtask

    task automatic test_div_by_zero();
        write_regs(1'b1, 1'b0, 32'h11);
        write_regs(1'b0, 1'b1, 32'h22);
        checks++; if (HI !== 32'h11 || LO !== 32'h22) begin errors++; $display("FAIL mthi_mtlo: got HI %h LO %h expected 11 22", HI, LO); end
        run_op(OP_DIV, 32'd5, 32'd0);
        checks++; if (busy_cycles != 0) begin errors++; $display("FAIL dbz_busy: got %0d expected 0", busy_cycles); end
        checks++; if (done_at != 1 || done_pulses != 1) begin errors++; $display("FAIL dbz_done: got at %0d pulses %0d expected 1 1", done_at, done_pulses); end
        checks++; if (dbz_at != 1 || dbz_pulses != 1) begin errors++; $display("FAIL dbz_flag: got at %0d pulses %0d expected 1 1", dbz_at, dbz_pulses); end
        checks++; if (HI !== 32'h11 || LO !== 32'h22) begin errors++; $display("FAIL dbz_hilo: got HI %h LO %h expected 11 22", HI, LO); end
        write_regs(1'b0, 1'b1, 32'hABCD);
        checks++; if (LO !== 32'hABCD || HI !== 32'h11) begin errors++; $display("FAIL mtlo_after_dbz: got HI %h LO %h expected 11 abcd", HI, LO); end
    endtask

    task automatic test_flush();
        drive_start(OP_MULT, 32'd6, 32'd7);
        @(posedge Clock); #1;
        Start = 1'b1; Op = OP_MULTU; OperandA = 32'd1; OperandB = 32'd1;
        WriteHI = 1'b1; WriteData = 32'h5555;
        @(posedge Clock); #1;
        Start = 1'b0; WriteHI = 1'b0;
        repeat (7) begin @(posedge Clock); #1; end
        checks++; if (Busy !== 1'b1 || dbg_state !== CALC) begin errors++; $display("FAIL flush_pre_busy: got busy %b state %0d expected 1 %0d", Busy, dbg_state, CALC); end
        Flush = 1'b1;
        @(posedge Clock); #1;
        Flush = 1'b0;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL flush_idle: got busy %b expected 0", Busy); end
        busy_cycles = 0; done_pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (Busy) busy_cycles++;
            if (Done) done_pulses++;
            @(posedge Clock); #1;
        end
        checks++; if (done_pulses != 0 || busy_cycles != 0) begin errors++; $display("FAIL flush_quiet: got done %0d busy %0d expected 0 0", done_pulses, busy_cycles); end
        checks++; if (HI !== 32'h11 || LO !== 32'hABCD) begin errors++; $display("FAIL flush_hilo: got HI %h LO %h expected 11 abcd", HI, LO); end
    endtask

    task automatic test_async_reset();
        drive_start(OP_MULT, 32'd6, 32'd7);
        repeat (5) begin @(posedge Clock); #1; end
        #2;
        Reset_n = 1'b0;
        #1;
        checks++; if ({Busy, Done} !== 2'b00) begin errors++; $display("FAIL async_rst_flags: got busy/done %b expected 00", {Busy, Done}); end
        checks++; if (HI !== '0 || LO !== '0) begin errors++; $display("FAIL async_rst_hilo: got HI %h LO %h expected 0 0", HI, LO); end
        @(negedge Clock);
        Reset_n = 1'b1;
        run_op(OP_MULTU, 32'd3, 32'd4);
        checks++; if (LO !== 32'd12 || HI !== 32'd0) begin errors++; $display("FAIL post_rst_multu: got HI %h LO %h expected 0 c", HI, LO); end
        checks++; if (done_pulses != 1) begin errors++; $display("FAIL post_rst_done: got %0d expected 1", done_pulses); end
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_mult_then_divu();
        test_div_signed();
        test_div_by_zero();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
